// File: rtl/grey_disp.sv
// grey_disp: display-side consumer for a cascade of grey-coded decimal digit
// counters. Each digit arrives as a 5-bit single-step code in the counters'
// own clock domain. The block synchronizes the codes, validates and decodes
// them to BCD, and drives a time-multiplexed 7-segment display with a short
// dead time at the start of every digit slot.
module grey_disp #(
    parameter int pDIGITS   = 4,
    parameter int pSCAN_DIV = 1024,
    parameter int pBLANK_LZ = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [5*pDIGITS-1:0]   i_codes,
    input  logic                   i_err_clr,
    output logic [6:0]             o_seg,
    output logic [pDIGITS-1:0]     o_dig,
    output logic                   o_err
);

    localparam int PRE_W  = $clog2(pSCAN_DIV);
    localparam int SLOT_W = (pDIGITS > 1) ? $clog2(pDIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(pSCAN_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ZERO  = {PRE_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(pDIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};

    // Grey code of digit 0: reset value of the synchronizer flops.
    localparam logic [4:0] CODE_ZERO = 5'b11000;
    // Decoded digit format: {invalid, bcd[3:0]}; this is a valid zero.
    localparam logic [4:0] DEC_ZERO  = 5'b0_0000;
    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Scan FSM states: dead time at prescaler 0, digit lit otherwise.
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    // Maps a grey digit code to {invalid, bcd}. Anything outside the ten
    // legal codes is flagged invalid with a zero BCD field.
    function automatic logic [4:0] decode_code(input logic [4:0] code);
        logic [4:0] res;
        case (code)
            5'b11000: res = {1'b0, 4'd0};
            5'b11001: res = {1'b0, 4'd1};
            5'b10001: res = {1'b0, 4'd2};
            5'b10011: res = {1'b0, 4'd3};
            5'b00011: res = {1'b0, 4'd4};
            5'b00111: res = {1'b0, 4'd5};
            5'b00110: res = {1'b0, 4'd6};
            5'b01110: res = {1'b0, 4'd7};
            5'b01100: res = {1'b0, 4'd8};
            5'b11100: res = {1'b0, 4'd9};
            default:  res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

    // Active-high segment pattern (bit0 = a ... bit6 = g) for a BCD value.
    function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
        logic [6:0] res;
        case (bcd)
            4'd0:    res = 7'h3F;
            4'd1:    res = 7'h06;
            4'd2:    res = 7'h5B;
            4'd3:    res = 7'h4F;
            4'd4:    res = 7'h66;
            4'd5:    res = 7'h6D;
            4'd6:    res = 7'h7D;
            4'd7:    res = 7'h07;
            4'd8:    res = 7'h7F;
            4'd9:    res = 7'h6F;
            default: res = SEG_DASH;
        endcase
        return res;
    endfunction

    logic [5*pDIGITS-1:0]      meta_r;
    logic [5*pDIGITS-1:0]      sync_r;
    logic [pDIGITS-1:0][4:0]   dec_nxt_s;
    logic [pDIGITS-1:0][4:0]   dec_r;
    logic                      any_inv_s;
    logic [pDIGITS-1:0]        blank_s;
    logic                      err_r;
    logic [PRE_W-1:0]          presc_r;
    logic [PRE_W-1:0]          presc_nxt_s;
    logic [SLOT_W-1:0]         slot_r;
    logic [SLOT_W-1:0]         slot_nxt_s;
    logic [0:0]                state_nxt_s;
    logic [pDIGITS-1:0]        slot_hot_s;
    logic [4:0]                cur_dec_s;
    logic                      cur_blank_s;
    logic [6:0]                seg_nxt_s;
    logic [pDIGITS-1:0]        dig_nxt_s;
    logic [6:0]                seg_r;
    logic [pDIGITS-1:0]        dig_r;

    // Two-flop synchronizer per code bit; single-bit stepping keeps every
    // sample equal to either the old or the new legal code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_r <= {pDIGITS{CODE_ZERO}};
            sync_r <= {pDIGITS{CODE_ZERO}};
        end else begin
            meta_r <= i_codes;
            sync_r <= meta_r;
        end
    end

    // Decode every synchronized code to {invalid, bcd}.
    always_comb begin
        dec_nxt_s = {pDIGITS{DEC_ZERO}};
        for (int k = 0; k < pDIGITS; k++) begin
            dec_nxt_s[k] = decode_code(sync_r[5*k +: 5]);
        end
    end

    // Decoded digit register, refreshed every cycle (no per-slot snapshot).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dec_r <= {pDIGITS{DEC_ZERO}};
        end else begin
            dec_r <= dec_nxt_s;
        end
    end

    // Invalid summary and leading-zero blanking, walking from the top digit
    // down; an invalid digit breaks the run of zeros like any non-zero.
    always_comb begin : lz_blk
        logic run_v;
        any_inv_s = 1'b0;
        blank_s   = {pDIGITS{1'b0}};
        run_v     = 1'b1;
        for (int k = pDIGITS - 1; k >= 0; k--) begin
            any_inv_s  = any_inv_s | dec_r[k][4];
            run_v      = run_v & (dec_r[k] == DEC_ZERO);
            blank_s[k] = (pBLANK_LZ != 0) && (k != 0) && run_v;
        end
    end

    // Sticky error flag; a new invalid digit takes priority over a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_r <= 1'b0;
        end else if (any_inv_s) begin
            err_r <= 1'b1;
        end else if (i_err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    // Next prescaler/slot values; the slot advances when the prescaler wraps.
    always_comb begin
        if (presc_r == PRE_LAST) begin
            presc_nxt_s = PRE_ZERO;
            slot_nxt_s  = (slot_r == SLOT_LAST) ? SLOT_ZERO : slot_r + SLOT_W'(1);
        end else begin
            presc_nxt_s = presc_r + PRE_W'(1);
            slot_nxt_s  = slot_r;
        end
        state_nxt_s = (presc_nxt_s == PRE_ZERO) ? ST_BLANK : ST_ON;
    end

    // Prescaler and slot index registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_r <= PRE_ZERO;
            slot_r  <= SLOT_ZERO;
        end else begin
            presc_r <= presc_nxt_s;
            slot_r  <= slot_nxt_s;
        end
    end

    // Select the digit of the upcoming slot and form the next output pattern.
    // Outputs are computed from the next scan state so the registered pins
    // line up with the prescaler/slot registers.
    always_comb begin
        slot_hot_s = {pDIGITS{1'b0}};
        cur_dec_s  = DEC_ZERO;
        for (int k = 0; k < pDIGITS; k++) begin
            slot_hot_s[k] = (slot_nxt_s == SLOT_W'(k));
            cur_dec_s     = cur_dec_s | ({5{slot_hot_s[k]}} & dec_r[k]);
        end
        cur_blank_s = |(blank_s & slot_hot_s);
        case (state_nxt_s)
            ST_ON: begin
                dig_nxt_s = slot_hot_s;
                seg_nxt_s = cur_blank_s  ? SEG_OFF  :
                            cur_dec_s[4] ? SEG_DASH : seg_pattern(cur_dec_s[3:0]);
            end
            ST_BLANK: begin
                dig_nxt_s = {pDIGITS{1'b0}};
                seg_nxt_s = SEG_OFF;
            end
            default: begin
                dig_nxt_s = {pDIGITS{1'b0}};
                seg_nxt_s = SEG_OFF;
            end
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_r <= SEG_OFF;
            dig_r <= {pDIGITS{1'b0}};
        end else begin
            seg_r <= seg_nxt_s;
            dig_r <= dig_nxt_s;
        end
    end

    assign o_seg = seg_r;
    assign o_dig = dig_r;
    assign o_err = err_r;

endmodule

// File: tb/tb_grey_disp.sv
`timescale 1ns/1ns
// Self-checking bench for grey_disp (4 digits, 8-cycle slots, blanking on).
module tb_grey_disp;

    localparam int D    = 4;
    localparam int DIV  = 8;
    localparam int SCAN = D * DIV;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic [5*D-1:0] i_codes = '0;
    logic           i_err_clr = 1'b0;
    logic [6:0]     o_seg;
    logic [D-1:0]   o_dig;
    logic           o_err;

    grey_disp #(.pDIGITS(D), .pSCAN_DIV(DIV), .pBLANK_LZ(1)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_codes   (i_codes),
        .i_err_clr (i_err_clr),
        .o_seg     (o_seg),
        .o_dig     (o_dig),
        .o_err     (o_err)
    );

    always #50 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;
    int edges;
    int exp_val [D];
    int cur_v, prev_v;
    logic [6:0] hist [$];

    logic [4:0] code_tab [10] = '{5'b11000, 5'b11001, 5'b10001, 5'b10011, 5'b00011,
                                  5'b00111, 5'b00110, 5'b01110, 5'b01100, 5'b11100};
    logic [6:0] pat_tab  [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Clock edges since reset release: the scan position follows from it.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) edges <= 0;
        else          edges <= edges + 1;
    end

    // Pattern a digit should show when its slot is lit (-1 = invalid).
    function automatic logic [6:0] model_seg(input int k);
        bit zeros = 1'b1;
        if (exp_val[k] < 0) return 7'h40;
        for (int j = k; j < D; j++) if (exp_val[j] != 0) zeros = 1'b0;
        if (k != 0 && zeros) return 7'h00;
        return pat_tab[exp_val[k]];
    endfunction

    function automatic logic [D-1:0] model_dig();
        if (edges % DIV == 0) return '0;
        return D'(1) << ((edges / DIV) % D);
    endfunction

    function automatic logic [6:0] model_out_seg();
        if (edges % DIV == 0) return 7'h00;
        return model_seg((edges / DIV) % D);
    endfunction

    task automatic check_dig(input string tag);
        logic [D-1:0] ed = model_dig();
        vectors++;
        assert (o_dig === ed) else begin
            miscompares++;
            $error("FAIL %s o_dig @edge %0d: got %b expected %b", tag, edges, o_dig, ed);
        end
    endtask

    task automatic check_now(input string tag);
        logic [6:0] es = model_out_seg();
        check_dig(tag);
        vectors++;
        assert (o_seg === es) else begin
            miscompares++;
            $error("FAIL %s o_seg @edge %0d: got %h expected %h", tag, edges, o_seg, es);
        end
    endtask

    task automatic check_err(input string tag, input logic exp);
        vectors++;
        assert (o_err === exp) else begin
            miscompares++;
            $error("FAIL %s o_err: got %b expected %b", tag, o_err, exp);
        end
    endtask

    task automatic step_check(input string tag);
        @(negedge i_clk);
        check_now(tag);
    endtask

    task automatic apply_num(input int v3, input int v2, input int v1, input int v0);
        exp_val[3] = v3; exp_val[2] = v2; exp_val[1] = v1; exp_val[0] = v0;
        for (int k = 0; k < D; k++)
            i_codes[5*k +: 5] = (exp_val[k] < 0) ? 5'b10101 : code_tab[exp_val[k]];
    endtask

    task automatic settle();
        repeat (8) @(negedge i_clk);
    endtask

    task automatic check_scan(input string tag);
        repeat (SCAN) step_check(tag);
    endtask

    task automatic pulse_clr();
        @(negedge i_clk) i_err_clr = 1'b1;
        @(negedge i_clk) i_err_clr = 1'b0;
    endtask

    // One cycle of the asynchronous counting run on digit 0.
    task automatic count_cycle();
        logic ok;
        @(negedge i_clk);
        check_err("count_err", 1'b0);
        if (edges % DIV != 0 && (edges / DIV) % D == 0) begin
            ok = (o_seg === pat_tab[cur_v]) || (o_seg === pat_tab[prev_v]);
            vectors++;
            assert (ok === 1'b1) else begin
                miscompares++;
                $error("FAIL count_seg: got %h expected %h or %h", o_seg, pat_tab[prev_v], pat_tab[cur_v]);
            end
            if (hist.size() == 0 || hist[$] !== o_seg) hist.push_back(o_seg);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int off;
        logic [6:0] exp_hist [11];

        // Reset held with arbitrary codes: everything quiet.
        exp_val = '{0, 0, 0, 0};
        i_codes = 20'($urandom);
        repeat (3) begin
            @(negedge i_clk);
            check_now("rst_hold");
            check_err("rst_hold", 1'b0);
        end
        apply_num(0, 0, 0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 check_now("rst_c0");
        repeat (16) step_check("rst_scan");

        // Static values and leading-zero blanking.
        apply_num(1, 2, 3, 4); settle(); check_scan("v1234");
        apply_num(0, 0, 0, 7); settle(); check_scan("v0007");
        apply_num(0, 0, 0, 0); settle(); check_scan("v0000");
        apply_num(0, 1, 0, 0); settle(); check_scan("v0100");

        // Invalid code: dash, sticky error, clear behaviour.
        apply_num(1, -1, 3, 4);
        repeat (4) @(negedge i_clk);
        check_err("inv_set", 1'b1);
        settle(); check_scan("inv_scan");
        apply_num(1, 2, 3, 4); settle();
        check_err("inv_sticky", 1'b1);
        pulse_clr();
        check_err("inv_clr", 1'b0);
        apply_num(0, -1, 0, 0);
        repeat (5) @(negedge i_clk);
        pulse_clr();
        check_err("clr_vs_set", 1'b1);
        check_scan("inv_lz");
        apply_num(0, 0, 0, 0); settle();
        pulse_clr();
        check_err("clr_after", 1'b0);

        // Asynchronous counting on digit 0: 0..9 then wrap to 0.
        settle(); settle();
        cur_v = 0; prev_v = 0;
        for (int s = 1; s <= 10; s++) begin
            repeat ($urandom_range(45, 60)) count_cycle();
            @(negedge i_clk);
            off = $urandom_range(1, 99);
            #(off);
            prev_v = cur_v;
            cur_v  = s % 10;
            apply_num(0, 0, 0, cur_v);
        end
        repeat (60) count_cycle();
        exp_hist = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};
        vectors++;
        assert (hist.size() == 11) else begin
            miscompares++;
            $error("FAIL count_hist_len: got %0d expected %0d", hist.size(), 11);
        end
        for (int i = 0; i < 11; i++) begin
            if (i < hist.size()) begin
                vectors++;
                assert (hist[i] === exp_hist[i]) else begin
                    miscompares++;
                    $error("FAIL count_hist[%0d]: got %h expected %h", i, hist[i], exp_hist[i]);
                end
            end
        end

        // Reset during slot 2 ON, then the scan restarts from slot 0.
        apply_num(1, 2, 3, 4); settle();
        n = 0;
        while ((edges % SCAN) != 20 && n < 64) begin
            step_check("pre_rst");
            n++;
        end
        vectors++;
        assert ((edges % SCAN) == 20) else begin
            miscompares++;
            $error("FAIL reach_slot2: got edge %0d expected position %0d", edges % SCAN, 20);
        end
        vectors++;
        assert (o_dig === 4'b0100 && o_seg === 7'h5B) else begin
            miscompares++;
            $error("FAIL slot2_on: got dig %b seg %h expected 0100 5B", o_dig, o_seg);
        end
        #20 i_rst_n = 1'b0;
        #10;
        check_now("async_rst");
        check_err("async_rst", 1'b0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 check_dig("restart_c0");
        repeat (17) begin
            @(negedge i_clk);
            check_dig("restart");
        end
        settle(); check_scan("after_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
